// File: rtl/truth_table_sweeper.sv
// Drives all 16 w,x,y,z vectors into the breadboard block and checks r4/r5/r6 against golden
// functions. Define TTS_STOP_ON_FAIL_EN to end a sweep at the first mismatching vector.
`timescale 1ns/1ps
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       r4,
    input  logic       r5,
    input  logic       r6,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_idx,
    output logic       sample_valid,
    output logic [3:0] sample_idx,
    output logic [2:0] sample_bits,
    output logic       sample_err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    localparam logic [3:0] CntLast = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] cnt;
    logic       fail_seen;
    logic [2:0] golden;
    logic       mismatch;
    logic       stop_now;
    logic [4:0] err_next;

    // The vector register is the index itself, so w..z only move on an advance.
    assign {w, x, y, z} = idx;

    always_comb begin
        golden    = 3'b000;
        golden[2] = y & z;
        golden[1] = (~y & ~z) | (~w & ~x);
        golden[0] = (~w & ~x & z) | (~w & ~x & y) | (x & ~y & z) | (w & ~x & ~y & ~z);
    end

    assign mismatch = ({r4, r5, r6} != golden);
    assign err_next = err_count + {4'b0000, mismatch};

`ifdef TTS_STOP_ON_FAIL_EN
    assign stop_now = (idx == 4'd15) || mismatch;
`else
    assign stop_now = (idx == 4'd15);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= StIdle;
            idx            <= 4'd0;
            cnt            <= 4'd0;
            fail_seen      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_idx <= 4'd0;
            sample_valid   <= 1'b0;
            sample_idx     <= 4'd0;
            sample_bits    <= 3'b000;
            sample_err     <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                StIdle: begin
                    idx <= 4'd0;
                    if (start) begin
                        state          <= StRun;
                        busy           <= 1'b1;
                        cnt            <= 4'd0;
                        err_count      <= 5'd0;
                        first_fail_idx <= 4'd0;
                        pass           <= 1'b0;
                        fail_seen      <= 1'b0;
                    end
                end
                StRun: begin
                    if (cnt != CntLast) begin
                        cnt <= cnt + 4'd1;
                    end else begin
                        cnt          <= 4'd0;
                        sample_valid <= 1'b1;
                        sample_idx   <= idx;
                        sample_bits  <= {r4, r5, r6};
                        sample_err   <= mismatch;
                        err_count    <= err_next;
                        if (mismatch && !fail_seen) begin
                            fail_seen      <= 1'b1;
                            first_fail_idx <= idx;
                        end
                        if (stop_now) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 5'd0);
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                StDone: begin
                    // Hold the last vector through the done cycle, then park at 0000.
                    state <= StIdle;
                    idx   <= 4'd0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    idx   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-check stage that sits directly upstream of the four-input `breadboard` function block (outputs r4/r5/r6). On a start pulse it drives all 16 combinations of w,x,y,z into the block in ascending order, with w as the MSB. For each vector it waits a programmable settle time, then samples r4/r5/r6 and compares them against internally computed golden functions. It reports per-vector samples, a mismatch count, the first failing index and pass/fail, replacing the untimed software sweep with a synthesizable one.

## Interface
- SETTLE_CYCLES, 2, number of cycles each vector is held before sampling; legal range 1..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a sweep; ignored while busy
- r4, r5, r6  in  1 each  function outputs returned by the driven block
- w, x, y, z  out  1 each  stimulus vector bits, w = bit 3, z = bit 0
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse when a sweep completes
- pass  out  1  1 when the last completed sweep had zero mismatches; held until the next start
- err_count  out  5  mismatches in the current or last sweep (0..16)
- first_fail_idx  out  4  index of the first mismatching vector; 0 if there was none
- sample_valid  out  1  one-cycle pulse on each compare
- sample_idx  out  4  vector index being compared; valid with sample_valid
- sample_bits  out  3  {r4,r5,r6} captured; valid with sample_valid
- sample_err  out  1  captured bits differ from golden; valid with sample_valid

## Operation
- Golden functions, evaluated on the current vector:
  - f4 = y·z
  - f5 = y'z' + w'x'
  - f6 = w'x'z + w'x'y + xy'z + wx'y'z'
- Mismatch: {r4,r5,r6} != {f4,f5,f6}, compared as a 3-bit equality.
- States:
  - IDLE → RUN on start. On entry: idx=0, settle counter=0, err_count=0, first_fail_idx=0, pass=0, first-fail flag cleared.
  - RUN, settling: counter increments while counter < SETTLE_CYCLES−1.
  - RUN, compare cycle (counter == SETTLE_CYCLES−1):
    - sample_valid=1.
    - On mismatch, err_count += 1. On the first mismatch, first_fail_idx = idx.
    - Then idx += 1 and the counter resets. If idx was 15, go to DONE.
  - DONE: done=1 and pass=(err_count==0) for one cycle, then IDLE.
- {w,x,y,z} are registered from idx and change only on a vector advance. They return to 0000 in IDLE.
- err_count cannot overflow: its maximum value is 16.
- start asserted in RUN or DONE is ignored and is not queued.

## Timing
- Reset (asynchronous, takes effect immediately) and outputs:
  - state=IDLE.
  - All outputs are 0: w..z, busy, done, pass, err_count, first_fail_idx, and all sample_* signals.
  - Reset asserted mid-sweep aborts the sweep with no done pulse and no partial pass.
- Start latency:
  - start is sampled at edge T0.
  - busy=1 and vector 0 is driven from cycle T0+1.
- Vector window:
  - Vector k is driven from cycle T0+1+k·S, where S=SETTLE_CYCLES.
  - It is compared in the last cycle of its S-cycle window, using the r-inputs present in that cycle.
- Sweep end:
  - done pulses in cycle T0+1+16·S.
  - busy falls in that same cycle.
  - A new start can be accepted in the done cycle+1 or later.
- The r-inputs are treated as combinational from w..z. At least one full cycle of settling is guaranteed because S≥1.

## Configuration
- TTS_STOP_ON_FAIL_EN:
  - Defined: the first mismatch ends the sweep. The FSM goes to DONE right after that compare, so err_count=1, pass=0, and w..z hold the failing vector until IDLE.
  - Undefined: all 16 vectors are always applied.

## Test plan
- Correct DUT model, SETTLE_CYCLES=2, start at T0:
  - 16 sample_valid pulses with sample_idx 0..15, all with sample_err=0.
  - done at T0+33; pass=1, err_count=0, first_fail_idx=0.
- r6 forced to 0, macro undefined:
  - sample_err=1 at idx 1, 2, 3, 5, 8, 13.
  - err_count=6, first_fail_idx=1, pass=0.
- r4 forced to 1, macro undefined:
  - Mismatch on every idx except 3, 7, 11, 15.
  - err_count=12, first_fail_idx=0.
- r6 forced to 0, TTS_STOP_ON_FAIL_EN defined:
  - done after the idx-1 compare; err_count=1, first_fail_idx=1.
  - w..z = 0001 during the done cycle.
- rst_n pulsed low while idx=7:
  - All outputs go to 0 immediately and no done is seen.
  - A fresh start then completes a full sweep with pass=1.
- start re-asserted at idx=4 mid-sweep: no restart, and done timing is unchanged.
- start asserted during the done cycle: ignored.
